// File: rtl/gray_code_counter_if.sv
// Control and status bundle for gray_code_counter.
// The master drives count controls and the slave returns the count views.
interface gray_code_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] flip;
    logic             tc;

    modport master (
        output en, up, load, load_val,
        input  gray_out, bin_out, flip, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output gray_out, bin_out, flip, tc
    );
endinterface

// File: rtl/gray_code_counter.sv
// Parametrised Gray-code counter with load, up/down, wrap or saturate,
// a binary shadow count and per-edge changed-bit reporting.
module gray_code_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic                clk,
    input  logic                res,
    gray_code_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};

    logic [WIDTH-1:0] b_q,    b_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] flip_q, flip_d;
    logic [WIDTH-1:0] load_bin;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(bus.load_val >> i);
        end
    end

    always_comb begin
        b_d = b_q;
        if (bus.load) begin
            b_d = load_bin;
        end else if (bus.en) begin
            if (bus.up) begin
                if (b_q != MAX_VAL) begin
                    b_d = b_q + 1'b1;
                end else if (WRAP) begin
                    b_d = MIN_VAL;
                end
            end else begin
                if (b_q != MIN_VAL) begin
                    b_d = b_q - 1'b1;
                end else if (WRAP) begin
                    b_d = MAX_VAL;
                end
            end
        end
    end

    // A load takes the Gray word verbatim; otherwise re-encode the new count.
    always_comb begin
        gray_d = bus.load ? bus.load_val : (b_d ^ (b_d >> 1));
        flip_d = gray_d ^ gray_q;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            b_q    <= '0;
            gray_q <= '0;
            flip_q <= '0;
        end else begin
            b_q    <= b_d;
            gray_q <= gray_d;
            flip_q <= flip_d;
        end
    end

    assign bus.gray_out = gray_q;
    assign bus.bin_out  = b_q;
    assign bus.flip     = flip_q;
    assign bus.tc       = bus.up ? (b_q == MAX_VAL) : (b_q == MIN_VAL);
endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: a wrapping and a saturating instance.
module tb_gray_code_counter;
    logic clk = 1'b0;
    logic res_w;
    logic res_s;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gray_code_counter_if #(.WIDTH(4)) bw ();
    gray_code_counter_if #(.WIDTH(4)) bs ();

    gray_code_counter #(.WIDTH(4), .WRAP(1'b1)) dut_w (.clk(clk), .res(res_w), .bus(bw.slave));
    gray_code_counter #(.WIDTH(4), .WRAP(1'b0)) dut_s (.clk(clk), .res(res_s), .bus(bs.slave));

    typedef struct {
        logic       res;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] exp_gray;
        logic [3:0] exp_bin;
        logic [3:0] exp_flip;
        logic       exp_tc;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] gseq [16];

    function automatic void add(input logic r, input logic e, input logic u, input logic l,
                                input logic [3:0] lv, input logic [3:0] g, input logic [3:0] b,
                                input logic [3:0] f, input logic t, input string n);
        vec_t v;
        v.res = r; v.en = e; v.up = u; v.load = l; v.load_val = lv;
        v.exp_gray = g; v.exp_bin = b; v.exp_flip = f; v.exp_tc = t; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] fl;
        logic [3:0] prev;

        gseq[0]  = 4'h0; gseq[1]  = 4'h1; gseq[2]  = 4'h3; gseq[3]  = 4'h2;
        gseq[4]  = 4'h6; gseq[5]  = 4'h7; gseq[6]  = 4'h5; gseq[7]  = 4'h4;
        gseq[8]  = 4'hC; gseq[9]  = 4'hD; gseq[10] = 4'hF; gseq[11] = 4'hE;
        gseq[12] = 4'hA; gseq[13] = 4'hB; gseq[14] = 4'h9; gseq[15] = 4'h8;

        //   res en up ld  lv    gray  bin   flip  tc
        add(1, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, "reset");
        for (int k = 1; k <= 16; k++) begin
            prev = gseq[(k - 1) % 16];
            fl   = gseq[k % 16] ^ prev;
            add(0, 1, 1, 0, 4'h0, gseq[k % 16], 4'(k % 16), fl, (k == 15), "count_up");
        end
        add(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1, "idle_tc_down");
        add(0, 1, 0, 0, 4'h0, 4'h8, 4'hF, 4'h8, 0, "down_wrap");
        add(0, 0, 1, 1, 4'h3, 4'h3, 4'h2, 4'hB, 0, "load_0011");
        add(0, 1, 1, 1, 4'hD, 4'hD, 4'h9, 4'hE, 0, "load_beats_en");
        add(0, 1, 1, 0, 4'h0, 4'hF, 4'hA, 4'h2, 0, "step_after_load");
        add(0, 0, 1, 1, 4'h6, 4'h6, 4'h4, 4'h9, 0, "load_0110");
        add(1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, "mid_reset");
        add(0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 4'h1, 0, "resume_after_reset");
        add(0, 0, 1, 1, 4'h1, 4'h1, 4'h1, 4'h0, 0, "load_same_no_flip");
        add(0, 0, 1, 1, 4'h7, 4'h7, 4'h5, 4'h6, 0, "load_0111");
        add(0, 1, 1, 0, 4'h0, 4'h5, 4'h6, 4'h2, 0, "rev_up");
        add(0, 1, 0, 0, 4'h0, 4'h7, 4'h5, 4'h2, 0, "rev_down");
        add(0, 1, 1, 0, 4'h0, 4'h5, 4'h6, 4'h2, 0, "rev_up_again");
        add(0, 0, 1, 0, 4'h0, 4'h5, 4'h6, 4'h0, 0, "idle_hold");
        add(1, 1, 0, 1, 4'hF, 4'h0, 4'h0, 4'h0, 1, "reset_beats_load");

        res_w = 1'b0; bw.en = 1'b0; bw.up = 1'b1; bw.load = 1'b0; bw.load_val = 4'h0;
        res_s = 1'b1; bs.en = 1'b0; bs.up = 1'b1; bs.load = 1'b0; bs.load_val = 4'h0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            res_w       = vecs[i].res;
            bw.en       = vecs[i].en;
            bw.up       = vecs[i].up;
            bw.load     = vecs[i].load;
            bw.load_val = vecs[i].load_val;
            if (vecs[i].name == "down_wrap") begin
                #1;
                chk("down_wrap_tc_before", 16'(bw.tc), 16'(1'b1));
            end
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_gray"}, 16'(bw.gray_out), 16'(vecs[i].exp_gray));
            chk({vecs[i].name, "_bin"},  16'(bw.bin_out),  16'(vecs[i].exp_bin));
            chk({vecs[i].name, "_flip"}, 16'(bw.flip),     16'(vecs[i].exp_flip));
            chk({vecs[i].name, "_tc"},   16'(bw.tc),       16'(vecs[i].exp_tc));
            if (vecs[i].en && !vecs[i].load && !vecs[i].res)
                chk({vecs[i].name, "_popcount"}, 16'($countones(bw.flip)), 16'd1);
        end

        // Saturating instance: hold at 0 going down, then climb and stick at 1111.
        @(negedge clk);
        res_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_s = 1'b0; bs.en = 1'b1; bs.up = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_low_gray", 16'(bs.gray_out), 16'h0);
        chk("sat_low_flip", 16'(bs.flip), 16'h0);
        chk("sat_low_tc", 16'(bs.tc), 16'h1);
        @(negedge clk);
        bs.up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k < 16) begin
                chk($sformatf("sat_up%0d_bin", k), 16'(bs.bin_out), 16'(k));
                chk($sformatf("sat_up%0d_gray", k), 16'(bs.gray_out), 16'(gseq[k]));
                chk($sformatf("sat_up%0d_pop", k), 16'($countones(bs.flip)), 16'd1);
            end else begin
                chk($sformatf("sat_hold%0d_bin", k), 16'(bs.bin_out), 16'hF);
                chk($sformatf("sat_hold%0d_gray", k), 16'(bs.gray_out), 16'h8);
                chk($sformatf("sat_hold%0d_flip", k), 16'(bs.flip), 16'h0);
                chk($sformatf("sat_hold%0d_tc", k), 16'(bs.tc), 16'h1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
